// File: rtl/string_plot_pkg.sv
// string_plot_pkg: shared types and defaults for the string plot sequencer.
// Holds the FSM state enum and default geometry/timeout parameters.
package string_plot_pkg;

  localparam int DEF_MAX_CHARS   = 16;
  localparam int DEF_CHAR_STEP   = 8;
  localparam int DEF_X_MAX       = 319;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_PULSE,
    S_CLR_ACK,
    S_CLR_DONE,
    S_ISSUE,
    S_PLOT_PULSE,
    S_PLOT_ACK,
    S_PLOT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

endpackage

// File: rtl/string_plot_sequencer_char_buffer.sv
// char_buffer: DEPTH x 8 register file, sync write, async read, sync clear.
// Ports: clk, reset, wr_en/wr_idx/wr_data write port, rd_idx -> rd_data.
module char_buffer #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);

  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= 8'h00;
    end else if (wr_en && int'(wr_idx) < DEPTH) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/string_plot_sequencer.sv
// string_plot_sequencer: walks a buffered word through the char drawer.
// In: start/clear_first/base/length, buffer write port, drawer ready.
// Out: address/x_input/y_input, plot/clear pulses, busy, done, flags.
module string_plot_sequencer
  import string_plot_pkg::*;
#(
  parameter int MAX_CHARS   = DEF_MAX_CHARS,
  parameter int CHAR_STEP   = DEF_CHAR_STEP,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_first,
  input  logic [8:0] base_x,
  input  logic [8:0] base_y,
  input  logic [4:0] length,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       ready_to_start_character,
  output logic [7:0] address,
  output logic [8:0] x_input,
  output logic [8:0] y_input,
  output logic       enable_character_plot,
  output logic       enable_clear,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       timeout_err
);

  state_t     state, next;
  logic [8:0] bx_q, by_q;
  logic [4:0] len_q, len_in, idx_nxt;
  logic [3:0] idx;
  logic [7:0] tmo_cnt, rd_data;
  logic [9:0] x_sum;
  logic       rdy, accept, tmo_hit, x_over, in_ack;

  assign rdy     = ready_to_start_character;
  assign len_in  = (length > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : length;
  assign idx_nxt = {1'b0, idx} + 5'd1;
  assign x_sum   = 10'(bx_q) + 10'(idx) * 10'(CHAR_STEP);
  assign x_over  = x_sum > 10'(X_MAX);
  assign in_ack  = (state == S_CLR_ACK) || (state == S_PLOT_ACK);
  assign tmo_hit = tmo_cnt == 8'(ACK_TIMEOUT - 1);
  // A clear request can only be launched into an idle drawer.
  assign accept  = (state == S_IDLE) && start
                 && (!clear_first || rdy);

  char_buffer #(.DEPTH(MAX_CHARS)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !busy),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (accept) begin
        if (clear_first)    next = S_CLR_PULSE;
        else if (len_in == 0) next = S_FINISH;
        else                next = S_ISSUE;
      end
      S_CLR_PULSE: next = S_CLR_ACK;
      S_CLR_ACK: begin
        if (!rdy)        next = S_CLR_DONE;
        else if (tmo_hit) next = S_FINISH;
      end
      S_CLR_DONE: if (rdy)
        next = (len_q == 0) ? S_FINISH : S_ISSUE;
      S_ISSUE: begin
        if (x_over)   next = S_FINISH;
        else if (rdy) next = S_PLOT_PULSE;
      end
      S_PLOT_PULSE: next = S_PLOT_ACK;
      S_PLOT_ACK: begin
        if (!rdy)        next = S_PLOT_DONE;
        else if (tmo_hit) next = S_FINISH;
      end
      S_PLOT_DONE: if (rdy) next = S_NEXT;
      S_NEXT: next = (idx_nxt == len_q) ? S_FINISH : S_ISSUE;
      S_FINISH: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse
  // lines up exactly with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q                  <= '0;
      by_q                  <= '0;
      len_q                 <= '0;
      idx                   <= '0;
      tmo_cnt               <= '0;
      address               <= '0;
      x_input               <= '0;
      y_input               <= '0;
      enable_character_plot <= 1'b0;
      enable_clear          <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      overflow              <= 1'b0;
      timeout_err           <= 1'b0;
    end else begin
      enable_character_plot <= next == S_PLOT_PULSE;
      enable_clear          <= next == S_CLR_PULSE;
      done                  <= next == S_FINISH;
      busy                  <= next != S_IDLE;
      tmo_cnt <= in_ack ? tmo_cnt + 8'd1 : 8'd0;
      if (accept) begin
        bx_q        <= base_x;
        by_q        <= base_y;
        len_q       <= len_in;
        idx         <= '0;
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == S_ISSUE) begin
        if (x_over) begin
          overflow <= 1'b1;
        end else begin
          address <= rd_data;
          x_input <= x_sum[8:0];
          y_input <= by_q;
        end
      end
      if (in_ack && rdy && tmo_hit)
        timeout_err <= 1'b1;
      if (state == S_NEXT)
        idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_string_plot_sequencer.sv
// tb_string_plot_sequencer: scoreboard bench for string_plot_sequencer.
// Drawer model + expected event queue checked by a negedge monitor.
module tb_string_plot_sequencer;

  localparam logic [1:0] K_PLOT = 2'd0;
  localparam logic [1:0] K_CLR  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic [8:0] x;
    logic [8:0] y;
    logic       ovf;
    logic       tmo;
  } ev_t;

  logic       clk = 0;
  logic       reset = 1;
  logic       start = 0, clear_first = 0;
  logic [8:0] base_x = 0, base_y = 0;
  logic [4:0] length = 0;
  logic       wr_en = 0;
  logic [3:0] wr_idx = 0;
  logic [7:0] wr_data = 0;
  logic       ready;
  logic [7:0] address;
  logic [8:0] x_input, y_input;
  logic       enable_character_plot, enable_clear;
  logic       busy, done, overflow, timeout_err;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0, n_plots = 0;
  int  bcnt = 0;
  logic stuck = 0;

  always #5 clk = ~clk;

  string_plot_sequencer dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .clear_first              (clear_first),
    .base_x                   (base_x),
    .base_y                   (base_y),
    .length                   (length),
    .wr_en                    (wr_en),
    .wr_idx                   (wr_idx),
    .wr_data                  (wr_data),
    .ready_to_start_character (ready),
    .address                  (address),
    .x_input                  (x_input),
    .y_input                  (y_input),
    .enable_character_plot    (enable_character_plot),
    .enable_clear             (enable_clear),
    .busy                     (busy),
    .done                     (done),
    .overflow                 (overflow),
    .timeout_err              (timeout_err)
  );

  // Drawer model: drops ready for 30 cycles after each request.
  always @(posedge clk) begin
    if (reset) begin
      ready <= 1'b1;
      bcnt  <= 0;
    end else if ((enable_character_plot || enable_clear) && !stuck) begin
      ready <= 1'b0;
      bcnt  <= 30;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) ready <= 1'b1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic [1:0] k, logic [7:0] a, logic [8:0] x,
                      logic [8:0] y, logic ovf, logic tmo);
    ev_t e;
    e.kind = k; e.a = a; e.x = x; e.y = y; e.ovf = ovf; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic got(logic [1:0] k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected event: got kind %0d want none", k);
      return;
    end
    e = exp_q.pop_front();
    chk("kind", 32'(k), 32'(e.kind));
    if (k == K_PLOT) begin
      chk("address", 32'(address), 32'(e.a));
      chk("x_input", 32'(x_input), 32'(e.x));
      chk("y_input", 32'(y_input), 32'(e.y));
    end
    if (k == K_DONE) begin
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (enable_character_plot) begin
        n_plots++;
        got(K_PLOT);
      end
      if (enable_clear) got(K_CLR);
      if (done) got(K_DONE);
    end
  end

  task automatic wr(logic [3:0] i, logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_idx = i; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic go(logic [8:0] bx, logic [8:0] by,
                    logic [4:0] len, logic clr);
    @(negedge clk);
    base_x = bx; base_y = by; length = len;
    clear_first = clr; start = 1;
    @(negedge clk);
    start = 0; clear_first = 0;
  endtask

  task automatic drain(string nm, int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || busy); i++)
      @(negedge clk);
    chk(nm, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle(string nm);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".plot"}, 32'(enable_character_plot), 0);
    chk({nm, ".clear"}, 32'(enable_clear), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".addr"}, 32'(address), 0);
    chk({nm, ".x"}, 32'(x_input), 0);
    chk({nm, ".y"}, 32'(y_input), 0);
    chk({nm, ".ovf"}, 32'(overflow), 0);
    chk({nm, ".tmo"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    reset = 0;

    // CAT with start-to-plot latency check.
    wr(0, 8'h43); wr(1, 8'h41); wr(2, 8'h54);
    push(K_PLOT, 8'h43, 10, 20, 0, 0);
    push(K_PLOT, 8'h41, 18, 20, 0, 0);
    push(K_PLOT, 8'h54, 26, 20, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 0);
    go(10, 20, 3, 0);
    chk("lat.busy", 32'(busy), 1);
    chk("lat.plot_k1", 32'(enable_character_plot), 0);
    @(posedge clk); #1;
    chk("lat.plot_k2", 32'(enable_character_plot), 1);
    drain("cat.drain", 400);

    // Clear pass only.
    push(K_CLR, 0, 0, 0, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 0);
    go(0, 0, 0, 1);
    drain("clr.drain", 200);

    // Right-edge overflow.
    push(K_PLOT, 8'h43, 300, 5, 0, 0);
    push(K_PLOT, 8'h41, 308, 5, 0, 0);
    push(K_PLOT, 8'h54, 316, 5, 0, 0);
    push(K_DONE, 0, 0, 0, 1, 0);
    go(300, 5, 5, 0);
    drain("ovf.drain", 400);

    // Start and write while busy are ignored.
    push(K_PLOT, 8'h43, 10, 20, 0, 0);
    push(K_PLOT, 8'h41, 18, 20, 0, 0);
    push(K_PLOT, 8'h54, 26, 20, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 0);
    go(10, 20, 3, 0);
    repeat (5) @(negedge clk);
    start = 1; base_x = 100; base_y = 100; length = 1;
    wr_en = 1; wr_idx = 1; wr_data = 8'hFF;
    @(negedge clk);
    start = 0; wr_en = 0;
    drain("ign.drain", 400);

    // Drawer never drops ready.
    stuck = 1;
    push(K_PLOT, 8'h43, 0, 0, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 1);
    go(0, 0, 1, 0);
    drain("tmo.drain", 600);
    stuck = 0;
    push(K_PLOT, 8'h43, 0, 0, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 0);
    go(0, 0, 1, 0);
    chk("tmo.cleared", 32'(timeout_err), 0);
    drain("tmo2.drain", 200);

    // Reset in PLOT_DONE of the second character.
    p0 = n_plots;
    push(K_PLOT, 8'h43, 10, 20, 0, 0);
    push(K_PLOT, 8'h41, 18, 20, 0, 0);
    go(10, 20, 3, 0);
    for (int i = 0; i < 300 && n_plots < p0 + 2; i++)
      @(negedge clk);
    chk("rst.reached", 32'(n_plots - p0), 2);
    repeat (5) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk_idle("midrst");
    @(negedge clk);
    reset = 0;
    chk("rst.queue", 32'(exp_q.size()), 0);
    repeat (40) @(negedge clk);

    // Buffer was cleared by reset.
    push(K_PLOT, 8'h00, 0, 0, 0, 0);
    push(K_PLOT, 8'h00, 8, 0, 0, 0);
    push(K_DONE, 0, 0, 0, 0, 0);
    go(0, 0, 2, 0);
    drain("bufclr.drain", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
